// File: rtl/cpu_clk_pkg.sv
// Shared encodings for the CPU clock controller: mode inputs, divider states
// and the legacy half-period.
package cpu_clk_pkg;

   localparam logic [1:0] MODE_RUN  = 2'b00;
   localparam logic [1:0] MODE_HALT = 2'b01;
   localparam logic [1:0] MODE_STEP = 2'b10;

   typedef enum logic [1:0] {
      S_LOW  = 2'b00,
      S_HIGH = 2'b01,
      S_HOLD = 2'b10
   } state_e;

   localparam int DEFAULT_HALF = 4;

endpackage

// File: rtl/btn_debounce.sv
// Button debouncer: two-flop synchroniser, stable-level filter and a one-cycle
// pulse on each accepted 0->1 transition. Release never pulses.
module btn_debounce #(
   parameter int DB_W      = 16,
   parameter int DB_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic level,
   output logic rise_pulse
);

   logic            sync1_q, sync2_q;
   logic            level_q, level_d;
   logic            rise_q, rise_d;
   logic [DB_W-1:0] cnt_q, cnt_d;

   // NOTE: every always_comb output is given a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == DB_W'(DB_CYCLES - 1)) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + DB_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level      = level_q;
   assign rise_pulse = rise_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock controller: programmable divider with run/halt/single-step modes,
// a clock-enable pulse on every div_clk rise and a retired-cycle counter.
module cpu_clk_ctrl
   import cpu_clk_pkg::*;
#(
   parameter int CNT_W        = 16,
   parameter int DEFAULT_HALF = cpu_clk_pkg::DEFAULT_HALF,
   parameter int DB_W         = 16,
   parameter int DB_CYCLES    = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CNT_W-1:0] div_half,
   input  logic [1:0]       mode,
   input  logic             step_btn,
   output logic             div_clk,
   output logic             clk_en,
   output logic             running,
   output logic [31:0]      cycle_count
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] half_q, half_d;
   logic [CNT_W-1:0] half_req;
   logic             phase_end;
   logic             div_clk_q, div_clk_d;
   logic             clk_en_q, clk_en_d;
   logic [31:0]      count_q, count_d;
   logic             btn_level, btn_rise, step_pulse;

   btn_debounce #(
      .DB_W      (DB_W),
      .DB_CYCLES (DB_CYCLES)
   ) u_step_db (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (step_btn),
      .level      (btn_level),
      .rise_pulse (btn_rise)
   );

   assign step_pulse = btn_rise & btn_level;

   always_comb begin
      half_req  = (div_half == '0) ? CNT_W'(1) : div_half;
      phase_end = (cnt_q == half_q - CNT_W'(1));
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_W'(1);
      half_d    = half_q;
      clk_en_d  = 1'b0;
      count_d   = count_q;

      // The new half-period is only picked up where a phase ends, so the phase in flight keeps its length.
      case (state_q)
         S_LOW: begin
            if (phase_end) begin
               cnt_d   = '0;
               half_d  = half_req;
               state_d = (mode == MODE_RUN) ? S_HIGH : S_HOLD;
            end
         end
         S_HIGH: begin
            if (phase_end) begin
               cnt_d   = '0;
               half_d  = half_req;
               state_d = S_LOW;
            end
         end
         S_HOLD: begin
            cnt_d = '0;
            if (mode == MODE_RUN) begin
               state_d = S_LOW;
            end else if (mode == MODE_STEP && step_pulse) begin
               state_d = S_HIGH;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = S_LOW;
         end
      endcase

      if (state_d == S_HIGH && state_q != S_HIGH) begin
         clk_en_d = 1'b1;
         count_d  = count_q + 32'd1;
      end
      div_clk_d = (state_d == S_HIGH);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_LOW;
         cnt_q     <= '0;
         half_q    <= CNT_W'(DEFAULT_HALF);
         div_clk_q <= 1'b0;
         clk_en_q  <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         half_q    <= half_d;
         div_clk_q <= div_clk_d;
         clk_en_q  <= clk_en_d;
         count_q   <= count_d;
      end
   end

   assign div_clk     = div_clk_q;
   assign clk_en      = clk_en_q;
   assign running     = (state_q != S_HOLD);
   assign cycle_count = count_q;

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Self-checking bench for cpu_clk_ctrl: a vector table for steady RUN timing,
// plus hand-written sequences for half changes, halt, step and mid-run reset.
module tb_cpu_clk_ctrl;
   import cpu_clk_pkg::*;

   localparam int DB_CYC = 8;

   typedef struct packed {
      logic        div;
      logic        en;
      logic        run;
      logic [31:0] cnt;
   } exp_t;

   typedef struct {
      logic        rst;
      logic [1:0]  mode;
      logic [15:0] half;
      logic        btn;
      exp_t        exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] div_half = 16'd4;
   logic [1:0]  mode = MODE_RUN;
   logic        step_btn = 1'b0;
   logic        div_clk, clk_en, running;
   logic [31:0] cycle_count;

   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   exp_t exp_q[$];
   vec_t tbl[$];

   cpu_clk_ctrl #(
      .CNT_W        (16),
      .DEFAULT_HALF (4),
      .DB_W         (16),
      .DB_CYCLES    (DB_CYC)
   ) dut (
      .clk         (clk),
      .reset       (reset_n),
      .div_half    (div_half),
      .mode        (mode),
      .step_btn    (step_btn),
      .div_clk     (div_clk),
      .clk_en      (clk_en),
      .running     (running),
      .cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   function automatic exp_t mk(input logic d, input logic e, input logic r, input int c);
      exp_t x;
      x.div = d;
      x.en  = e;
      x.run = r;
      x.cnt = 32'(c);
      return x;
   endfunction

   // Free-running waveform: first rise at 'first', half-period 'h', count starts at 'base'+1.
   function automatic exp_t run_wave(input int t, input int first, input int h, input int base);
      int p;
      if (t < first) return mk(1'b0, 1'b0, 1'b1, base);
      p = (t - first) % (2 * h);
      return mk(p < h, p == 0, 1'b1, base + (t - first) / (2 * h) + 1);
   endfunction

   function automatic logic btn_sched(input int k);
      return (k < 2) || (k >= 5 && k < 7) || (k >= 10 && k < 12) ||
             (k >= 15 && k < 35) || (k >= 50 && k < 70);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic tick(input logic r, input logic [1:0] m, input logic [15:0] h, input logic b);
      reset_n  = r;
      mode     = m;
      div_half = h;
      step_btn = b;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic apply(input string tag, input logic r, input logic [1:0] m,
                        input logic [15:0] h, input logic b, input exp_t e);
      exp_t x;
      exp_q.push_back(e);
      tick(r, m, h, b);
      x = exp_q.pop_front();
      check({tag, ".div_clk"}, div_clk, x.div);
      check({tag, ".clk_en"}, clk_en, x.en);
      check({tag, ".running"}, running, x.run);
      check({tag, ".cycle_count"}, cycle_count, x.cnt);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   r;
      logic b;

      // Table: reset, legacy divide-by-8, reset again, then div_half=0 (treated as 1).
      for (int i = 0; i < 2; i++) tbl.push_back('{1'b0, MODE_RUN, 16'd4, 1'b0, mk(0, 0, 1, 0)});
      for (int t = 1; t <= 24; t++) tbl.push_back('{1'b1, MODE_RUN, 16'd4, 1'b0, run_wave(t, 4, 4, 0)});
      tbl.push_back('{1'b0, MODE_RUN, 16'd0, 1'b0, mk(0, 0, 1, 0)});
      for (int t = 1; t <= 20; t++) tbl.push_back('{1'b1, MODE_RUN, 16'd0, 1'b0, run_wave(t, 4, 1, 0)});

      foreach (tbl[i]) apply("table", tbl[i].rst, tbl[i].mode, tbl[i].half, tbl[i].btn, tbl[i].exp);

      // div_half drops to 2 during the first high phase: that phase still ends at 8.
      apply("half_chg_rst", 1'b0, MODE_RUN, 16'd4, 1'b0, mk(0, 0, 1, 0));
      for (int t = 1; t <= 21; t++) begin
         if (t < 10) apply("half_chg", 1'b1, MODE_RUN, (t >= 7) ? 16'd2 : 16'd4, 1'b0,
                           (t >= 4 && t < 8) ? mk(1, t == 4, 1, 1) : mk(0, 0, 1, (t >= 4) ? 1 : 0));
         else apply("half_chg", 1'b1, MODE_RUN, 16'd2, 1'b0, run_wave(t, 10, 2, 1));
      end

      // HALT mid high phase, then back to RUN from HOLD.
      apply("halt_rst", 1'b0, MODE_RUN, 16'd4, 1'b0, mk(0, 0, 1, 0));
      for (int t = 1; t <= 24; t++) begin
         exp_t e;
         if (t < 4)       e = mk(0, 0, 1, 0);
         else if (t < 8)  e = mk(1, t == 4, 1, 1);
         else if (t < 12) e = mk(0, 0, 1, 1);
         else if (t < 17) e = mk(0, 0, 0, 1);
         else if (t < 21) e = mk(0, 0, 1, 1);
         else             e = mk(1, t == 21, 1, 2);
         apply("halt", 1'b1, (t >= 6 && t <= 16) ? MODE_HALT : MODE_RUN, 16'd4, 1'b0, e);
      end

      // Reset pulse while div_clk is high, then legacy timing from the release.
      apply("rst_mid_pre", 1'b0, MODE_RUN, 16'd4, 1'b0, mk(0, 0, 1, 0));
      for (int t = 1; t <= 5; t++) apply("rst_mid_pre", 1'b1, MODE_RUN, 16'd4, 1'b0, run_wave(t, 4, 4, 0));
      apply("rst_mid", 1'b0, MODE_RUN, 16'd4, 1'b0, mk(0, 0, 1, 0));
      for (int t = 1; t <= 13; t++) apply("rst_mid_post", 1'b1, MODE_RUN, 16'd4, 1'b0, run_wave(t, 4, 4, 0));

      // Mode 11 behaves as HALT: the first low phase ends in HOLD; half 20 is latched there.
      apply("step_rst", 1'b0, 2'b11, 16'd20, 1'b0, mk(0, 0, 1, 0));
      for (int t = 1; t <= 4; t++) apply("step_pre", 1'b1, 2'b11, 16'd20, 1'b0, mk(0, 0, t < 4, 0));

      // Bouncy press, held press, then a second press landing inside the step period.
      r = -1;
      for (int k = 0; k <= 100; k++) begin
         b = btn_sched(k);
         if (r < 0) begin
            tick(1'b1, MODE_STEP, 16'd20, b);
            if (div_clk === 1'b1) begin
               r = k;
               check("step_rise.clk_en", clk_en, 1'b1);
               check("step_rise.cycle_count", cycle_count, 32'd1);
               check("step_rise.window", (r >= 15 + DB_CYC && r <= 15 + DB_CYC + 4), 1'b1);
            end else begin
               check("step_wait.running", running, 1'b0);
            end
         end else begin
            apply("step_period", 1'b1, MODE_STEP, 16'd20, b, mk((k - r) < 20, 1'b0, (k - r) < 40, 1));
         end
      end
      check("step_rise.found", r >= 0, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
